// File: rtl/tdc_stream_rx.sv
// Receive-side sink for the TDC result stream: folds frames of 1-3 beats into
// one record (peak beat, summed intensity, beat count, error) and queues them.
module tdc_stream_rx #(
    parameter int DATA_W = 10,
    parameter int INT_W  = 5,
    parameter int DEPTH  = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] s_data,
    input  logic [INT_W-1:0]  s_int,
    input  logic [1:0]        s_num,
    input  logic              s_last,
    input  logic              s_valid,
    output logic              s_ready,
    input  logic              flush,
    output logic [DATA_W-1:0] m_tof,
    output logic [INT_W-1:0]  m_int,
    output logic [6:0]        m_sum,
    output logic [1:0]        m_beats,
    output logic              m_err,
    output logic              m_valid,
    input  logic              m_ready,
    output logic [15:0]       frame_cnt,
    output logic [7:0]        err_cnt
);

    localparam int AW    = $clog2(DEPTH);
    localparam int REC_W = DATA_W + INT_W + 7 + 2 + 1;

    typedef enum logic {
        IDLE,
        COLLECT
    } state_t;

    state_t state, state_nxt;

    logic              ready_en;
    logic              full;
    logic              empty;
    logic              accept;
    logic              push;
    logic              pop;
    logic              rec_err;
    logic [REC_W-1:0]  rec;

    logic [1:0]        exp_num,  exp_num_nxt;
    logic [DATA_W-1:0] best_tof, best_tof_nxt;
    logic [INT_W-1:0]  best_int, best_int_nxt;
    logic [6:0]        sum,      sum_nxt;
    logic [1:0]        cnt,      cnt_nxt;

    logic [AW:0]       count;
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic [REC_W-1:0]  mem [DEPTH];

    // ready_en keeps s_ready low until the first clock after reset release
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ready_en <= 1'b0;
        end else begin
            ready_en <= 1'b1;
        end
    end

    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign s_ready = ready_en && !full && !flush;
    assign accept  = s_valid && s_ready;
    assign m_valid = !empty;
    assign pop     = m_valid && m_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        exp_num_nxt  = exp_num;
        best_tof_nxt = best_tof;
        best_int_nxt = best_int;
        sum_nxt      = sum;
        cnt_nxt      = cnt;
        push         = 1'b0;
        rec_err      = 1'b0;
        case (state)
            IDLE: begin
                if (accept) begin
                    exp_num_nxt  = s_num;
                    best_tof_nxt = s_data;
                    best_int_nxt = s_int;
                    sum_nxt      = 7'(s_int);
                    cnt_nxt      = 2'd1;
                    if (s_last) begin
                        push    = 1'b1;
                        rec_err = (s_num != 2'd1);
                    end else begin
                        state_nxt = COLLECT;
                    end
                end
            end
            COLLECT: begin
                if (accept) begin
                    cnt_nxt = cnt + 2'd1;
                    sum_nxt = sum + 7'(s_int);
                    // strictly greater: on a tie the earlier beat stays the peak
                    if (s_int > best_int) begin
                        best_tof_nxt = s_data;
                        best_int_nxt = s_int;
                    end
                    if (s_last || cnt_nxt == 2'd3) begin
                        push      = 1'b1;
                        state_nxt = IDLE;
                        rec_err   = (exp_num == 2'd0) || (cnt_nxt != exp_num) || !s_last;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
        if (flush) begin
            state_nxt = IDLE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            exp_num  <= '0;
            best_tof <= '0;
            best_int <= '0;
            sum      <= '0;
            cnt      <= '0;
        end else begin
            exp_num  <= exp_num_nxt;
            best_tof <= best_tof_nxt;
            best_int <= best_int_nxt;
            sum      <= sum_nxt;
            cnt      <= cnt_nxt;
        end
    end

    // The record is built from the next-state values so it commits with the terminating beat
    assign rec = {best_tof_nxt, best_int_nxt, sum_nxt, cnt_nxt, rec_err};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= rec;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    assign {m_tof, m_int, m_sum, m_beats, m_err} = mem[rd_ptr];

    // push only happens on an accepted beat, which flush already blocks
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frame_cnt <= '0;
            err_cnt   <= '0;
        end else if (push) begin
            frame_cnt <= frame_cnt + 16'd1;
            if (rec_err && err_cnt != 8'hFF) begin
                err_cnt <= err_cnt + 8'd1;
            end
        end
    end

endmodule
